xt_hb_master_arbiter: RTL

- Round-robin arbiter that shares the single XT_HB high-speed bus among MASTER_NUM masters, for example the RISC-V core plus a future DMA or debug master.
- Sits between the masters and the bus-side input of XT_HB. It serialises read and write transactions, issues the grant vectors, and generates per-master stall_req.
- It also guards each transaction with a timeout so that an unresponsive device cannot hang the bus.

---
 rtl/xt_hb_master_arbiter_pkg.sv | 7 +
 rtl/xt_hb_master_arbiter_rr_first_picker.sv | 33 +++
 rtl/xt_hb_master_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/xt_hb_master_arbiter_pkg.sv
// Shared types for the XT_HB master arbiter and its round-robin picker.
package xt_hb_master_arbiter_pkg;
  localparam int HB_ARB_IDX_W = 3;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} hb_arb_state_e;
  typedef enum logic {HB_OP_READ, HB_OP_WRITE} hb_op_e;
endpackage

// File: rtl/xt_hb_master_arbiter_rr_first_picker.sv
// Combinational rotate-and-find-first: first set bit of req at or above ptr, wrapping.
module rr_first_picker
  import xt_hb_master_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]              req,
  input  logic [HB_ARB_IDX_W-1:0]   ptr,
  output logic [HB_ARB_IDX_W-1:0]   idx,
  output logic                      valid
);
  logic [2*N-1:0]          dbl;
  logic [HB_ARB_IDX_W-1:0] off;
  logic [HB_ARB_IDX_W:0]   sum;

  // Doubling req lets a plain right shift act as a rotate.
  assign dbl = {req, req} >> ptr;

  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        valid = 1'b1;
        off   = HB_ARB_IDX_W'(k);
      end
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = (sum >= (HB_ARB_IDX_W+1)'(N)) ? HB_ARB_IDX_W'(sum - (HB_ARB_IDX_W+1)'(N))
                                              : sum[HB_ARB_IDX_W-1:0];
endmodule

// File: rtl/xt_hb_master_arbiter.sv
// Round-robin arbiter serialising master reads/writes onto XT_HB, with a per-transaction timeout.
module xt_hb_master_arbiter
  import xt_hb_master_arbiter_pkg::*;
#(
  parameter int MASTER_NUM     = 2,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       hb_clk,
  input  logic                       rst,
  input  logic [MASTER_NUM-1:0]      m_read,
  input  logic [MASTER_NUM-1:0]      m_write,
  input  logic [MASTER_NUM*ADDR_W-1:0] m_raddr,
  input  logic [MASTER_NUM*ADDR_W-1:0] m_waddr,
  input  logic [MASTER_NUM*32-1:0]   m_wdata,
  input  logic [MASTER_NUM*2-1:0]    m_write_width,
  input  logic                       read_finish,
  input  logic                       write_finish,
  output logic                       bus_read,
  output logic                       bus_write,
  output logic [ADDR_W-1:0]          bus_raddr,
  output logic [ADDR_W-1:0]          bus_waddr,
  output logic [31:0]                bus_wdata,
  output logic [1:0]                 bus_write_width,
  output logic [MASTER_NUM-1:0]      read_grant,
  output logic [MASTER_NUM-1:0]      write_grant,
  output logic [MASTER_NUM-1:0]      stall_req,
  output logic                       bus_timeout,
  output logic [2:0]                 timeout_master
);
  localparam int IW    = HB_ARB_IDX_W;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IW-1:0]    LAST_IDX = IW'(MASTER_NUM - 1);

  hb_arb_state_e          state, nstate;
  hb_op_e                 op;
  logic [IW-1:0]          owner, rr_ptr, tm, pick_idx, ptr_next;
  logic [CNT_W-1:0]       cnt;
  logic                   pick_vld, own_rd, own_wr, own_req, fin_match, to_hit, done_any;
  logic [MASTER_NUM-1:0]  req, own_oh, pick_oh;
  logic [ADDR_W-1:0]      sel_raddr, sel_waddr;
  logic [31:0]            sel_wdata;
  logic [1:0]             sel_width;

  assign req = m_read | m_write;

  rr_first_picker #(.N(MASTER_NUM)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  for (genvar i = 0; i < MASTER_NUM; i++) begin : g_oh
    assign own_oh[i]  = (owner == IW'(i));
    assign pick_oh[i] = (pick_idx == IW'(i));
  end

  assign own_rd    = |(m_read & own_oh);
  assign own_wr    = |(m_write & own_oh);
  assign own_req   = (op == HB_OP_READ) ? own_rd : own_wr;
  assign fin_match = (op == HB_OP_READ) ? read_finish : write_finish;
  assign to_hit    = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign ptr_next  = (owner == LAST_IDX) ? '0 : IW'(owner + 1'b1);

  always_comb begin
    sel_raddr = '0;
    sel_waddr = '0;
    sel_wdata = '0;
    sel_width = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (own_oh[i]) begin
        sel_raddr = m_raddr[i*ADDR_W +: ADDR_W];
        sel_waddr = m_waddr[i*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata[i*32 +: 32];
        sel_width = m_write_width[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge hb_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (pick_vld) nstate = BUSY;
      // A finish beats a coincident timeout; a withdrawn request drops quietly.
      BUSY:    if (fin_match)     nstate = IDLE;
               else if (!own_req) nstate = IDLE;
               else if (to_hit)   nstate = ABORT;
      ABORT:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    bus_read        = 1'b0;
    bus_write       = 1'b0;
    bus_raddr       = '0;
    bus_waddr       = '0;
    bus_wdata       = '0;
    bus_write_width = '0;
    read_grant      = '0;
    write_grant     = '0;
    bus_timeout     = 1'b0;
    done_any        = 1'b0;
    case (state)
      BUSY: begin
        bus_read        = (op == HB_OP_READ);
        bus_write       = (op == HB_OP_WRITE);
        bus_raddr       = sel_raddr;
        bus_waddr       = sel_waddr;
        bus_wdata       = sel_wdata;
        bus_write_width = sel_width;
        read_grant      = (op == HB_OP_READ)  ? own_oh : '0;
        write_grant     = (op == HB_OP_WRITE) ? own_oh : '0;
        done_any        = fin_match;
      end
      ABORT: begin
        bus_timeout = 1'b1;
        done_any    = 1'b1;
      end
      default: ;
    endcase
    stall_req = rst ? '0 : (req & ~(own_oh & {MASTER_NUM{done_any}}));
  end

  assign timeout_master = tm;

  always_ff @(posedge hb_clk or posedge rst) begin
    if (rst) begin
      owner  <= '0;
      op     <= HB_OP_READ;
      rr_ptr <= '0;
      cnt    <= '0;
      tm     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_vld) begin
            owner <= pick_idx;
            op    <= (|(m_read & pick_oh)) ? HB_OP_READ : HB_OP_WRITE;
          end
        end
        BUSY: begin
          if (fin_match) begin
            rr_ptr <= ptr_next;
            cnt    <= '0;
          end else if (!own_req) begin
            cnt <= '0;
          end else if (to_hit) begin
            tm  <= owner;
            cnt <= '0;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        ABORT: begin
          rr_ptr <= ptr_next;
          cnt    <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
